p256_square_host_port: RTL and testbench
========================================

# p256_square_host_port

Memory-side responder and host stream adapter for the P-256 modular squaring core. It accepts a 256-bit operand from a host as eight 32-bit words on a valid/ready stream and holds them in an operand bank. The squaring core reads that bank through its word-address port, and its result writes are captured in a result bank. When the core signals ready, the result is streamed back to the host as eight words and the core is held in reset again.

## Interface
- TIMEOUT_CYCLES, 4095: maximum RUN cycles before abort. Used only with P256_HOST_TIMEOUT_EN; 12-bit counter, range 1..4095.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  host operand word valid
- in_ready  out  1  block accepts operand word
- in_data  in  32  operand word, least-significant word first
- out_valid  out  1  result word valid
- out_ready  in  1  host accepts result word
- out_data  out  32  result word, least-significant word first
- out_last  out  1  high with word 7 of the result
- busy  out  1  high in RUN and DRAIN
- err  out  1  sticky timeout flag; constant 0 without the macro
- core_rst_n  out  1  registered active-low reset to the core
- core_ena  out  1  registered enable to the core
- core_rdy  in  1  core done flag
- core_a_addr  in  3  core operand read address
- core_a_din  out  32  operand word returned to the core
- core_d_addr  in  3  core result write address
- core_d_wren  in  1  core result write enable
- core_d_dout  in  32  core result write data

## Operation
- States: LOAD, RUN, DRAIN. Reset state is LOAD.
- LOAD
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes in_data to op[wcnt] and increments the 3-bit wcnt.
  - The first accepted word clears err.
  - Accepting word 7 (wcnt==7) moves to RUN and wraps wcnt to 0.
- RUN
  - core_rst_n=1 and core_ena=1 (registered; asserted the cycle after the 8th accept).
  - Waits for core_rdy==1, then moves to DRAIN with rcnt=0.
- Operand read port: every cycle, core_a_din <= op[core_a_addr]. Latency is 1 cycle, which meets the core's 3-cycle settle. The port is active in every state.
- Result write port:
  - Every cycle with core_d_wren=1, res[core_d_addr] <= core_d_dout. Last write wins.
  - The core's transient stale-data write (new address, previous data for one cycle) is overwritten one cycle later. No filtering is applied.
- DRAIN
  - out_valid=1 and out_data=res[rcnt] (combinational read of the registered bank); out_last=(rcnt==7).
  - Each handshake increments rcnt.
  - The handshake on word 7 moves to LOAD. core_rst_n and core_ena drop to 0 the next cycle.
- In LOAD, core_rst_n=0 and core_ena=0, so the core is held in reset between operations.
- in_valid is ignored outside LOAD. core_rdy is ignored outside RUN.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, busy=0, err=0.
  - core_rst_n=0, core_ena=0, core_a_din=0.
  - wcnt=0, rcnt=0.
  - Banks are not cleared.
- Reset mid-operation aborts to LOAD. A partial operand is discarded (wcnt=0), and the core returns to reset on the same edge.
- Sequence: 8th accept at cycle t; core out of reset at t+1; core_rdy seen at cycle r; out_valid=1 at r+1.
- With out_ready held high, DRAIN lasts exactly 8 cycles.
- Back-to-back operations: in_ready=1 in the cycle after the last output handshake.
- out_data and out_last stay stable while out_valid&&!out_ready.

## Configuration
- P256_HOST_TIMEOUT_EN defined:
  - A 12-bit counter clears on RUN entry and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES without core_rdy, the block sets err=1, goes to LOAD, and drives core_rst_n=0. No result words are output.
  - If core_rdy and the timeout occur in the same cycle, core_rdy wins.
- Not defined: no counter; RUN waits indefinitely; err is tied to 0.

## Test plan
- Operand 0x…0001 (word0=1, others 0), out_ready=1: 8 outputs are word0=0x00000001 and words 1-7 = 0. out_last is high only on word 7; busy drops after it.
- Operand 2: result word0=0x00000004, rest 0. Then immediately load operand p-1 (0xffffffff00000001000000000000000000000000fffffffffffffffffffffffe): result is 1. This confirms core re-reset between operations.
- Random out_ready backpressure (50%) with operand 0x00…0003: out_data is held stable during stalls; sequence is 9, 0×7. Exactly 8 handshakes occur.
- in_valid toggled with gaps during LOAD: only accepted words are stored. core_rst_n rises exactly one cycle after the 8th accept.
- Assert rst_n low after 4 words and again mid-RUN: the block returns to LOAD with in_ready=1 and core_rst_n=0. A following full load produces the correct result.
- With P256_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, a core model that never raises core_rdy: err=1 after 16 RUN cycles, state returns to LOAD, out_valid never rises. err clears on the next accepted word.

Source files
------------

// File: rtl/p256_square_host_port_if.sv
// Host-side stream bundle for p256_square_host_port: operand words in, result words out.
// The master modport is the host and the slave modport is the adapter.
interface p256_square_host_port_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/p256_square_host_port.sv
// Host stream adapter and operand/result bank responder for the P-256 squaring core.
// Optional RUN timeout with a sticky err flag is enabled by defining P256_HOST_TIMEOUT_EN.
module p256_square_host_port
`ifdef P256_HOST_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 4095)
`endif
  (
  input  logic                         clk,
  input  logic                         rst_n,
  p256_square_host_port_if.slave       host,
  output logic                         busy,
  output logic                         err,
  output logic                         core_rst_n,
  output logic                         core_ena,
  input  logic                         core_rdy,
  input  logic [2:0]                   core_a_addr,
  output logic [31:0]                  core_a_din,
  input  logic [2:0]                   core_d_addr,
  input  logic                         core_d_wren,
  input  logic [31:0]                  core_d_dout
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t      r_state;
  logic [2:0]  r_wcnt;
  logic [2:0]  r_rcnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_core_rst_n;
  logic        r_core_ena;
  logic [31:0] r_a_din;
  logic [31:0] r_op  [8];
  logic [31:0] r_res [8];
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_timeout;

  assign w_in_fire  = host.in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && host.out_ready;

`ifdef P256_HOST_TIMEOUT_EN
  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);

  logic [11:0] r_tcnt;
  logic        r_err;

  // core_rdy in the same cycle as the limit takes priority over the abort.
  assign w_timeout = (r_state == S_RUN) && !core_rdy && (r_tcnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= (r_state == S_RUN) ? r_tcnt + 12'd1 : '0;
      if (w_timeout)
        r_err <= 1'b1;
      else if (w_in_fire && (r_wcnt == 3'd0))
        r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_core_ena   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_wcnt <= r_wcnt + 3'd1;
            if (r_wcnt == 3'd7) begin
              r_state      <= S_RUN;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b1;
              r_core_rst_n <= 1'b1;
              r_core_ena   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (core_rdy) begin
            r_state     <= S_DRAIN;
            r_rcnt      <= '0;
            r_out_valid <= 1'b1;
          end else if (w_timeout) begin
            r_state      <= S_LOAD;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_core_ena   <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            r_rcnt <= r_rcnt + 3'd1;
            if (r_rcnt == 3'd7) begin
              r_state      <= S_LOAD;
              r_out_valid  <= 1'b0;
              r_in_ready   <= 1'b1;
              r_busy       <= 1'b0;
              r_core_rst_n <= 1'b0;
              r_core_ena   <= 1'b0;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // NOTE: the banks carry no reset; every word is written before it is ever read back.
  always_ff @(posedge clk) begin
    if (w_in_fire)
      r_op[r_wcnt] <= host.in_data;
    if (core_d_wren)
      r_res[core_d_addr] <= core_d_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_a_din <= '0;
    else
      r_a_din <= r_op[core_a_addr];
  end

  assign host.in_ready  = r_in_ready;
  assign host.out_valid = r_out_valid;
  assign host.out_data  = r_res[r_rcnt];
  assign host.out_last  = r_out_valid && (r_rcnt == 3'd7);
  assign busy           = r_busy;
  assign core_rst_n     = r_core_rst_n;
  assign core_ena       = r_core_ena;
  assign core_a_din     = r_a_din;

endmodule

// File: tb/tb_p256_square_host_port.sv
// Directed bench for p256_square_host_port with a behavioural squaring-core model on the bank ports.
// With P256_HOST_TIMEOUT_EN a second instance (TIMEOUT_CYCLES=16, core never ready) covers the abort path.
module tb_p256_square_host_port;

  localparam logic [255:0] P256 =
    256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_ffffffff;
  localparam logic [255:0] PM1 =
    256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_fffffffe;
  localparam logic [255:0] OP_2P32  = 256'h1_00000000;
  localparam logic [255:0] RES_2P64 = 256'h1_00000000_00000000;
  localparam logic [255:0] OP_2P128 =
    256'h00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000000;
  localparam logic [255:0] RES_2P256 =
    256'h00000000_fffffffe_ffffffff_ffffffff_ffffffff_00000000_00000000_00000001;

  logic        clk;
  logic        rst_n;
  logic        busy, err, core_rst_n, core_ena;
  logic        core_rdy;
  logic [2:0]  core_a_addr;
  logic [31:0] core_a_din;
  logic [2:0]  core_d_addr;
  logic        core_d_wren;
  logic [31:0] core_d_dout;

  int n_checks = 0;
  int n_fail   = 0;
  bit cm_hang  = 1'b0;

  p256_square_host_port_if host ();

  p256_square_host_port u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host),
    .busy        (busy),
    .err         (err),
    .core_rst_n  (core_rst_n),
    .core_ena    (core_ena),
    .core_rdy    (core_rdy),
    .core_a_addr (core_a_addr),
    .core_a_din  (core_a_din),
    .core_d_addr (core_d_addr),
    .core_d_wren (core_d_wren),
    .core_d_dout (core_d_dout)
  );

`ifdef P256_HOST_TIMEOUT_EN
  logic        t_busy, t_err, t_core_rst_n, t_core_ena;
  logic        t_core_rdy;
  logic [2:0]  t_a_addr;
  logic [31:0] t_a_din;
  logic [2:0]  t_d_addr;
  logic        t_d_wren;
  logic [31:0] t_d_dout;

  p256_square_host_port_if host_to ();

  p256_square_host_port #(.TIMEOUT_CYCLES(16)) u_dut_to (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host_to),
    .busy        (t_busy),
    .err         (t_err),
    .core_rst_n  (t_core_rst_n),
    .core_ena    (t_core_ena),
    .core_rdy    (t_core_rdy),
    .core_a_addr (t_a_addr),
    .core_a_din  (t_a_din),
    .core_d_addr (t_d_addr),
    .core_d_wren (t_d_wren),
    .core_d_dout (t_d_dout)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: reads the operand over 8 cycles, squares mod p, writes each word
  // first with stale data and then with the correct data, then raises core_rdy.
  initial begin : core_model
    int            step;
    logic [255:0]  opv;
    logic [255:0]  resv;
    logic [511:0]  sq;
    logic [31:0]   prev;
    step = 0; opv = '0; resv = '0; sq = '0; prev = '0;
    core_rdy = 1'b0; core_a_addr = '0; core_d_addr = '0; core_d_wren = 1'b0; core_d_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (!(core_rst_n && core_ena)) begin
        step = 0; core_rdy = 1'b0; core_d_wren = 1'b0; core_a_addr = '0;
      end else if (cm_hang) begin
        core_d_wren = 1'b0;
      end else begin
        if (step >= 1 && step <= 8) opv[32*(step-1) +: 32] = core_a_din;
        if (step < 8) core_a_addr = 3'(step);
        if (step == 8) begin
          sq   = {256'd0, opv} * {256'd0, opv};
          sq   = sq % {256'd0, P256};
          resv = sq[255:0];
          prev = 32'ha5a5a5a5;
        end
        if (step >= 9 && step <= 24) begin
          core_d_wren = 1'b1;
          core_d_addr = 3'((step - 9) / 2);
          if (((step - 9) % 2) == 0) begin
            core_d_dout = prev;
          end else begin
            core_d_dout = resv[32*((step-9)/2) +: 32];
            prev        = core_d_dout;
          end
        end else begin
          core_d_wren = 1'b0;
        end
        if (step == 25) core_rdy = 1'b1;
        if (step < 26) step++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; gaps insert idle cycles with junk data.
  task automatic load_operand(input logic [255:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      host.in_valid = 1'b1;
      host.in_data  = v[32*i +: 32];
      check("in_ready_load", 32'(host.in_ready), 32'd1);
      if (i == 7) check("core_rst_n_before_last", 32'(core_rst_n), 32'd0);
      @(negedge clk);
      if (i == 0) check("err_after_first", 32'(err), 32'd0);
      if (i == 7) begin
        check("core_rst_n_after_last", 32'(core_rst_n), 32'd1);
        check("core_ena_after_last", 32'(core_ena), 32'd1);
        check("busy_run", 32'(busy), 32'd1);
        check("in_ready_run", 32'(host.in_ready), 32'd0);
      end
      if (gaps || i == 7) begin
        host.in_valid = 1'b0;
        host.in_data  = 32'hdeadbeef;
        if (gaps) repeat (i % 3) @(negedge clk);
      end
    end
  endtask

  task automatic wait_rdy();
    int budget = 0;
    while (!core_rdy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("rdy_seen", 32'(core_rdy), 32'd1);
    check("out_valid_at_rdy", 32'(host.out_valid), 32'd0);
    @(negedge clk);
    check("out_valid_after_rdy", 32'(host.out_valid), 32'd1);
  endtask

  task automatic drain_check(input logic [255:0] exp, input bit bp);
    int          k       = 0;
    int          vcycles = 0;
    int          budget  = 0;
    bit          stalled = 1'b0;
    logic [31:0] held    = '0;
    logic        held_last = 1'b0;
    while (k < 8 && budget < 400) begin
      if (host.out_valid) begin
        vcycles++;
        if (stalled) begin
          check("hold_data", host.out_data, held);
          check("hold_last", 32'(host.out_last), 32'(held_last));
        end
        host.out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (host.out_ready) begin
          check("out_data", host.out_data, exp[32*k +: 32]);
          check("out_last", 32'(host.out_last), 32'(k == 7));
          k++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held      = host.out_data;
          held_last = host.out_last;
        end
      end
      @(negedge clk);
      budget++;
    end
    check("handshakes", 32'(k), 32'd8);
    if (!bp) check("drain_cycles", 32'(vcycles), 32'd8);
    check("out_valid_end", 32'(host.out_valid), 32'd0);
    check("out_last_end", 32'(host.out_last), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("in_ready_end", 32'(host.in_ready), 32'd1);
    check("core_rst_n_end", 32'(core_rst_n), 32'd0);
    check("core_ena_end", 32'(core_ena), 32'd0);
    host.out_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(host.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(host.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_core_ena"}, 32'(core_ena), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    host.in_valid = 1'b0; host.in_data = '0; host.out_ready = 1'b1;
`ifdef P256_HOST_TIMEOUT_EN
    t_core_rdy = 1'b0; t_a_addr = '0; t_d_addr = '0; t_d_wren = 1'b0; t_d_dout = '0;
    host_to.in_valid = 1'b0; host_to.in_data = '0; host_to.out_ready = 1'b1;
`endif
    repeat (3) @(negedge clk);

    check_idle("reset");
    check("reset_out_last", 32'(host.out_last), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_a_din", core_a_din, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Operand 1, full-rate drain with latency checks around core_rdy.
    load_operand(256'd1, 1'b0);
    wait_rdy();
    drain_check(256'd1, 1'b0);

    // Operand 2 then p-1 back to back.
    load_operand(256'd2, 1'b0);
    drain_check(256'd4, 1'b0);
    load_operand(PM1, 1'b0);
    drain_check(256'd1, 1'b0);

    // Random backpressure.
    load_operand(256'd3, 1'b0);
    drain_check(256'd9, 1'b1);

    // Gapped operand load; only accepted words land in the bank.
    load_operand(OP_2P32, 1'b1);
    drain_check(RES_2P64, 1'b0);

    // Reset after 4 accepted words, then a full load.
    for (int i = 0; i < 4; i++) begin
      host.in_valid = 1'b1;
      host.in_data  = 32'hffff0000 | 32'(i);
      @(negedge clk);
    end
    host.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle("partial_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_operand(256'd7, 1'b0);
    drain_check(256'd49, 1'b0);

    // Reset in the middle of RUN, then a full load exercising the reduction.
    load_operand(256'd2, 1'b0);
    repeat (4) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("run_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_operand(OP_2P128, 1'b0);
    drain_check(RES_2P256, 1'b0);

`ifdef P256_HOST_TIMEOUT_EN
    begin : timeout_test
      int  cnt      = 0;
      bit  seen_out = 1'b0;
      check("to_err_reset", 32'(t_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
        host_to.in_valid = 1'b1;
        host_to.in_data  = 32'(i + 1);
        @(negedge clk);
      end
      host_to.in_valid = 1'b0;
      check("to_busy_run", 32'(t_busy), 32'd1);
      while (t_busy && cnt < 100) begin
        cnt++;
        if (host_to.out_valid) seen_out = 1'b1;
        @(negedge clk);
      end
      check("to_run_cycles", 32'(cnt), 32'd16);
      check("to_err_set", 32'(t_err), 32'd1);
      check("to_in_ready", 32'(host_to.in_ready), 32'd1);
      check("to_core_rst_n", 32'(t_core_rst_n), 32'd0);
      check("to_no_output", 32'(seen_out), 32'd0);
      check("to_out_valid", 32'(host_to.out_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("to_err_sticky", 32'(t_err), 32'd1);
      host_to.in_valid = 1'b1;
      host_to.in_data  = 32'h1;
      @(negedge clk);
      host_to.in_valid = 1'b0;
      check("to_err_cleared", 32'(t_err), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
